// File: rtl/feeder_pkg.sv
// Shared types and step arithmetic for the skewed data feeder.
// The final step index depends on FEEDER_SKEW_EN (diagonal skew on/off).
package feeder_pkg;

  typedef enum logic {IDLE, STREAM} feeder_state_t;

  function automatic int last_step(input int lanes, input int depth);
`ifdef FEEDER_SKEW_EN
    return depth + lanes - 2;
`else
    return depth - 1 + 0 * lanes;
`endif
  endfunction

endpackage

// File: rtl/feeder_lane.sv
// One feeder lane: holds its DEPTH-element slice of the tile and emits element (step - OFFSET).
// Outputs are registered; they update only on present edges and clear on clear edges.
module feeder_lane
  import feeder_pkg::*;
#(
  parameter int DEPTH  = 7,
  parameter int DATA_W = 8,
  parameter int STEP_W = 4,
  parameter int OFFSET = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      capture,
  input  logic                      clear,
  input  logic                      present,
  input  logic [DEPTH*DATA_W-1:0]   tile,
  input  logic [STEP_W-1:0]         step,
  output logic signed [DATA_W-1:0]  data_out,
  output logic                      lane_valid
);

  localparam int IDX_W = STEP_W + 1;

  logic [DEPTH*DATA_W-1:0] tile_q;
  logic [IDX_W-1:0]        rel;
  logic                    hit;
  logic [DATA_W-1:0]       elem;

  // Element 0 sits in the most-significant field of the lane slice.
  always_comb begin
    rel  = {1'b0, step} - IDX_W'(OFFSET);
    hit  = (step >= STEP_W'(OFFSET)) && (rel < IDX_W'(DEPTH));
    elem = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (rel == IDX_W'(e)) elem = tile_q[(DEPTH-1-e)*DATA_W +: DATA_W];
    end
    if (!hit) elem = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tile_q     <= '0;
      data_out   <= '0;
      lane_valid <= 1'b0;
    end else begin
      if (capture) tile_q <= tile;
      if (clear) begin
        data_out   <= '0;
        lane_valid <= 1'b0;
      end else if (present) begin
        data_out   <= elem;
        lane_valid <= hit;
      end
    end
  end

endmodule

// File: rtl/skewed_data_feeder.sv
// Captures a LANES x DEPTH tile via valid/ready, then streams it one step per enabled cycle.
// FEEDER_SKEW_EN: lane i delayed by i steps; undefined: lanes aligned. load_ready only in IDLE.
module skewed_data_feeder
  import feeder_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DEPTH  = 7,
  parameter int DATA_W = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            load_valid,
  output logic                            load_ready,
  input  logic [LANES*DEPTH*DATA_W-1:0]   data_in,
  output logic [LANES*DATA_W-1:0]         data_out,
  output logic [LANES-1:0]                lane_valid,
  output logic                            busy,
  output logic                            done
);

  localparam int LAST   = last_step(LANES, DEPTH);
  localparam int STEP_W = $clog2(DEPTH + LANES);

  feeder_state_t     state;
  logic [STEP_W-1:0] step_q;
  logic              capture;
  logic              clear;
  logic              present;

  assign capture    = (state == IDLE) && load_valid;
  assign clear      = (state == IDLE);
  assign present    = (state == STREAM) && enable;
  assign load_ready = (state == IDLE);
  assign busy       = (state == STREAM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      step_q <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load_valid) begin
            step_q <= '0;
            state  <= STREAM;
          end
        end
        STREAM: begin
          done <= 1'b0;
          if (enable) begin
            // Counter parks on LAST; the next load clears it.
            if (step_q == STEP_W'(LAST)) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef FEEDER_SKEW_EN
    localparam int OFFS = i;
`else
    localparam int OFFS = 0;
`endif
    feeder_lane #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .STEP_W (STEP_W),
      .OFFSET (OFFS)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .capture    (capture),
      .clear      (clear),
      .present    (present),
      .tile       (data_in[(i+1)*DEPTH*DATA_W-1 -: DEPTH*DATA_W]),
      .step       (step_q),
      .data_out   (data_out[(i+1)*DATA_W-1 -: DATA_W]),
      .lane_valid (lane_valid[i])
    );
  end

endmodule

// File: tb/tb_skewed_data_feeder.sv
// Directed bench for skewed_data_feeder with LANES=2, DEPTH=7, DATA_W=8; follows FEEDER_SKEW_EN.
module tb_skewed_data_feeder;

  localparam int LANES  = 2;
  localparam int DEPTH  = 7;
  localparam int DATA_W = 8;
`ifdef FEEDER_SKEW_EN
  localparam int NSTEPS = 8;
`else
  localparam int NSTEPS = 7;
`endif

  localparam logic [111:0] TILE_A = {56'hA1B2C3D4E5F607, 56'h11223344556677};
  localparam logic [111:0] TILE_B = {56'h5A5B5C5D5E5F60, 56'h99887766554433};

  logic                            clk = 1'b0;
  logic                            reset;
  logic                            enable;
  logic                            load_valid;
  logic                            load_ready;
  logic [LANES*DEPTH*DATA_W-1:0]   data_in;
  logic [LANES*DATA_W-1:0]         data_out;
  logic [LANES-1:0]                lane_valid;
  logic                            busy;
  logic                            done;

  int total = 0;
  int bad   = 0;
  int cyc;

  skewed_data_feeder #(
    .LANES  (LANES),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .data_in    (data_in),
    .data_out   (data_out),
    .lane_valid (lane_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {lane_valid, lane1, lane0} for tile A at step s.
  function automatic logic [17:0] exp_a(input int s);
    logic [17:0] r;
    case (s)
`ifdef FEEDER_SKEW_EN
      0: r = {2'b01, 16'h0011};
      1: r = {2'b11, 16'hA122};
      2: r = {2'b11, 16'hB233};
      3: r = {2'b11, 16'hC344};
      4: r = {2'b11, 16'hD455};
      5: r = {2'b11, 16'hE566};
      6: r = {2'b11, 16'hF677};
      7: r = {2'b10, 16'h0700};
`else
      0: r = {2'b11, 16'hA111};
      1: r = {2'b11, 16'hB222};
      2: r = {2'b11, 16'hC333};
      3: r = {2'b11, 16'hD444};
      4: r = {2'b11, 16'hE555};
      5: r = {2'b11, 16'hF666};
      6: r = {2'b11, 16'h0777};
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic check_step(input string tag, input int s, input logic dn);
    logic [17:0] e;
    e = exp_a(s);
    check({tag, "_dat"}, 32'(data_out), 32'(e[15:0]));
    check({tag, "_vld"}, 32'(lane_valid), 32'(e[17:16]));
    check({tag, "_done"}, 32'(done), 32'(dn));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dat"}, 32'(data_out), 32'h0);
    check({tag, "_vld"}, 32'(lane_valid), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_rdy"}, 32'(load_ready), 32'h1);
  endtask

  task automatic load_tile(input logic [111:0] t);
    load_valid = 1'b1;
    data_in    = t;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load_valid = 1'b0; data_in = '0;
    tick();
    reset = 1'b0;
    check_idle("reset");

    // Enable in IDLE without a load must not start anything.
    enable = 1'b1;
    tick();
    check_idle("idle_en");

    // Continuous enable.
    enable = 1'b0;
    load_tile(TILE_A);
    check("cap_busy", 32'(busy), 32'h1);
    check("cap_rdy", 32'(load_ready), 32'h0);
    check("cap_dat", 32'(data_out), 32'h0);
    enable = 1'b1;
    for (int s = 0; s < NSTEPS; s++) begin
      tick();
      check_step($sformatf("cont_s%0d", s), s, s == NSTEPS - 1);
    end
    tick();
    check_idle("cont_end");

    // Alternating enable: outputs hold on enable=0 cycles.
    enable = 1'b0;
    load_tile(TILE_A);
    cyc = 1;
    for (int s = 0; s < NSTEPS; s++) begin
      enable = 1'b1;
      tick();
      cyc++;
      check_step($sformatf("alt_s%0d", s), s, s == NSTEPS - 1);
      if (s == NSTEPS - 1) begin
        check("alt_cycles", 32'(cyc), 32'(2 * NSTEPS));
      end else begin
        enable = 1'b0;
        tick();
        cyc++;
        check_step($sformatf("alt_hold%0d", s), s, 1'b0);
      end
    end
    enable = 1'b0;
    tick();
    check_idle("alt_end");

    // Load while busy is ignored; load in the done cycle is accepted.
    load_tile(TILE_A);
    enable = 1'b1;
    for (int s = 0; s < NSTEPS; s++) begin
      if (s == 4) begin
        load_valid = 1'b1;
        data_in    = TILE_B;
      end
      tick();
      check_step($sformatf("ign_s%0d", s), s, s == NSTEPS - 1);
      check($sformatf("ign_rdy%0d", s), 32'(load_ready), 32'(s == NSTEPS - 1));
    end
    tick();
    load_valid = 1'b0;
    check("b2b_cap_dat", 32'(data_out), 32'h0);
    check("b2b_cap_vld", 32'(lane_valid), 32'h0);
    check("b2b_cap_busy", 32'(busy), 32'h1);
    tick();
`ifdef FEEDER_SKEW_EN
    check("b2b_s0_dat", 32'(data_out), 32'h0099);
    check("b2b_s0_vld", 32'(lane_valid), 32'h1);
`else
    check("b2b_s0_dat", 32'(data_out), 32'h5A99);
    check("b2b_s0_vld", 32'(lane_valid), 32'h3);
`endif
    tick(); tick(); tick();
`ifdef FEEDER_SKEW_EN
    check("b2b_s3_dat", 32'(data_out), 32'h5C66);
`else
    check("b2b_s3_dat", 32'(data_out), 32'h5D66);
`endif

    // Reset mid-stream, then a fresh load restarts at step 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("rst_mid");
    enable = 1'b0;
    load_tile(TILE_A);
    enable = 1'b1;
    tick();
    check_step("restart_s0", 0, 1'b0);
    enable = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
